md_arbiter: RTL
===============

# md_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle multiply/divide engine between two requesters, e.g. the primary pipeline's E stage and a secondary issue port. It accepts one operation at a time through a valid/ready handshake and drives the engine's start/operand interface. It waits for the engine's done pulse and returns HI/LO to the owning requester through a held valid/ready response channel. Divide-by-zero is short-circuited without engaging the engine, and a watchdog bounds engine wait time.

## Interface
- TIMEOUT, 31: maximum WAIT cycles before an error response; range 1..255.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- ireq_valid0 / ireq_valid1  in  1  requester 0/1 has an operation.
- ireq_op0 / ireq_op1  in  2  00 mult, 01 multu, 10 div, 11 divu.
- ireq_a0, ireq_b0 / ireq_a1, ireq_b1  in  32  operands: A = rs/dividend, B = rt/divisor.
- oreq_ready0 / oreq_ready1  out  1  accept strobe; a transfer occurs on valid & ready.
- ores_valid0 / ores_valid1  out  1  result held for requester 0/1.
- ires_ready0 / ires_ready1  in  1  requester consumes the result.
- ores_hi, ores_lo  out  32  shared result bus, valid only with ores_validX.
- ores_err  out  1  result produced by the watchdog, not by the engine.
- omd_start  out  1  one-cycle engine start pulse.
- omd_op  out  2  op code to the engine.
- omd_a, omd_b  out  32  operands to the engine, stable from the start cycle until done.
- imd_done  in  1  engine completion pulse.
- imd_hi, imd_lo  in  32  engine result, valid with imd_done.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Registers:
  - owner (1 bit).
  - last (1 bit): last-granted requester.
  - op/a/b latches.
  - hi/lo result registers.
  - err flag.
  - wdog (8-bit counter).
- Arbitration, combinational, in IDLE only:
  - If exactly one valid is high, that requester is granted.
  - If both are high, grant goes to the requester != last.
  - oreq_readyX = (state==IDLE) & grantX; at most one ready is high per cycle.
- IDLE:
  - On accept, latch op/a/b and set owner = granted requester.
  - Div-by-zero (op div/divu with b==0): hi = a, lo = 32'hFFFFFFFF, err = 0, go to RESP without touching the engine.
  - Otherwise go to ISSUE.
- ISSUE: omd_start = 1 for exactly this cycle, wdog cleared, go to WAIT.
- WAIT:
  - If imd_done: hi = imd_hi, lo = imd_lo, err = 0, go to RESP.
  - Else if wdog == TIMEOUT-1: hi = lo = 0, err = 1, go to RESP.
  - Else wdog increments.
- RESP:
  - ores_valid[owner] = 1, the other ores_valid = 0; ores_hi/lo/err driven from the registers.
  - On ires_ready[owner]: last = owner, go to IDLE.
  - ires_ready of the non-owner is ignored.
- imd_done is ignored outside WAIT.
- omd_op/omd_a/omd_b always reflect the latches, so they are stable throughout ISSUE and WAIT.
- No arithmetic is performed here apart from the div-by-zero constant.

## Timing
- Reset values:
  - state = IDLE, owner = 0, last = 1 (requester 0 wins the first tie).
  - All latches and counters = 0.
  - Every output = 0 except oreq_readyX, which follows arbitration combinationally from the first cycle after reset release.
- Normal op, accept at edge E:
  - omd_start high in cycle E+1.
  - WAIT from E+2.
  - imd_done sampled at edge D ≥ E+2 gives ores_valid from cycle D+1.
  - Minimum accept-to-valid latency is 3 cycles.
- Div-by-zero: ores_valid in cycle E+1 (1-cycle latency).
- Watchdog: with no done, ores_err = 1 and ores_valid rise exactly TIMEOUT+2 cycles after accept.
- Response back-pressure: ores_valid and the result bus hold unchanged while ires_ready = 0.
- Earliest next accept:
  - The cycle after the ires_ready handshake (one IDLE cycle minimum).
  - Throughput is therefore one op per 4 cycles at best.
- Simultaneous imd_done and watchdog expiry: done wins, err = 0.
- Asynchronous reset mid-operation:
  - Returns to IDLE at once and drops omd_start and ores_valid.
  - A later imd_done from the aborted op is ignored because the FSM is not in WAIT.

## Test plan
- Reset, then requester 0 issues mult a=32'hFFFFFFFE, b=3; engine done 5 cycles after start with hi=32'hFFFFFFFF, lo=32'hFFFFFFFA:
  - omd_start pulses once.
  - ores_valid0 appears the cycle after done with those values, err = 0.
- Both requesters valid continuously with ires_ready tied high:
  - Grants alternate 0,1,0,1.
  - Never both oreq_ready high.
  - Requester 0 is served first after reset.
- divu a=7, b=0 from requester 1:
  - No omd_start.
  - ores_valid1 one cycle after accept with hi=7, lo=32'hFFFFFFFF.
- TIMEOUT=4, engine never asserts done:
  - ores_valid0 with err = 1, hi = lo = 0, exactly 6 cycles after accept.
  - A stray imd_done afterwards is ignored.
- ires_ready0 held low for 10 cycles in RESP:
  - Outputs remain stable.
  - oreq_ready1 stays 0 despite ireq_valid1 = 1.
  - After the handshake, requester 1 is granted the next cycle.
- Assert reset in WAIT, then deassert and pulse imd_done:
  - All outputs return to 0 immediately.
  - No response is generated.
  - A new request is accepted normally.

Source files
------------

// File: rtl/md_arbiter.sv
// md_arbiter: two-requester round-robin front end for a shared
// multi-cycle mult/div engine, with div-by-zero bypass and watchdog.
module md_arbiter #(
    parameter int TIMEOUT = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid0,
    input  logic        ireq_valid1,
    input  logic [1:0]  ireq_op0,
    input  logic [1:0]  ireq_op1,
    input  logic [31:0] ireq_a0,
    input  logic [31:0] ireq_b0,
    input  logic [31:0] ireq_a1,
    input  logic [31:0] ireq_b1,
    output logic        oreq_ready0,
    output logic        oreq_ready1,
    output logic        ores_valid0,
    output logic        ores_valid1,
    input  logic        ires_ready0,
    input  logic        ires_ready1,
    output logic [31:0] ores_hi,
    output logic [31:0] ores_lo,
    output logic        ores_err,
    output logic        omd_start,
    output logic [1:0]  omd_op,
    output logic [31:0] omd_a,
    output logic [31:0] omd_b,
    input  logic        imd_done,
    input  logic [31:0] imd_hi,
    input  logic [31:0] imd_lo
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic        owner, last, err;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [7:0]  wdog;

    logic        grant0, grant1, accept, sel, div0;
    logic        res_ready, expired;
    logic [1:0]  sel_op;
    logic [31:0] sel_a, sel_b;

    // On a tie the requester that was not served last wins.
    assign grant0 = ireq_valid0 & (~ireq_valid1 | last);
    assign grant1 = ireq_valid1 & (~ireq_valid0 | ~last);

    assign oreq_ready0 = (state == IDLE) & grant0;
    assign oreq_ready1 = (state == IDLE) & grant1;
    assign accept      = oreq_ready0 | oreq_ready1;
    assign sel         = oreq_ready1;

    assign sel_op = sel ? ireq_op1 : ireq_op0;
    assign sel_a  = sel ? ireq_a1  : ireq_a0;
    assign sel_b  = sel ? ireq_b1  : ireq_b0;
    assign div0   = sel_op[1] & (sel_b == 32'd0);

    assign res_ready = owner ? ires_ready1 : ires_ready0;
    assign expired   = (wdog == 8'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = div0 ? RESP : ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (imd_done || expired) state_nx = RESP;
            RESP:  if (res_ready) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner <= 1'b0;
            last  <= 1'b1;
            op    <= 2'd0;
            a     <= 32'd0;
            b     <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            err   <= 1'b0;
            wdog  <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= sel;
                        op    <= sel_op;
                        a     <= sel_a;
                        b     <= sel_b;
                        if (div0) begin
                            hi  <= sel_a;
                            lo  <= 32'hFFFF_FFFF;
                            err <= 1'b0;
                        end
                    end
                end
                ISSUE: wdog <= 8'd0;
                WAIT: begin
                    // Done takes priority over a same-cycle expiry.
                    if (imd_done) begin
                        hi  <= imd_hi;
                        lo  <= imd_lo;
                        err <= 1'b0;
                    end else if (expired) begin
                        hi  <= 32'd0;
                        lo  <= 32'd0;
                        err <= 1'b1;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                RESP: if (res_ready) last <= owner;
            endcase
        end
    end

    assign omd_start   = (state == ISSUE);
    assign omd_op      = op;
    assign omd_a       = a;
    assign omd_b       = b;
    assign ores_valid0 = (state == RESP) & ~owner;
    assign ores_valid1 = (state == RESP) & owner;
    assign ores_hi     = hi;
    assign ores_lo     = lo;
    assign ores_err    = err;

endmodule
